// File: rtl/sram_pkg.sv
// Shared types and defaults for the external asynchronous SRAM arbiter.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 18;
    localparam int unsigned SRAM_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } sram_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } grant_id_e;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter; on a tie the port not granted last wins.
module sram_rr_arb
    import sram_pkg::*;
(
    input  logic      CLK,
    input  logic      reset_in,
    input  logic      req_a,
    input  logic      req_b,
    input  logic      advance,
    output logic      grant_valid,
    output grant_id_e grant_id
);

    grant_id_e last_grant;

    // Pick a winner from the current requests and the previous grant.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_id    = PORT_A;
        if (req_a && req_b) begin
            grant_id = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant_id = PORT_B;
        end
    end

    // Remember who was served; B after reset so A wins the first tie.
    always_ff @(posedge CLK) begin
        if (reset_in) begin
            last_grant <= PORT_B;
        end else if (advance && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for the external 16-bit async SRAM.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = SRAM_DATA_WIDTH,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  io_mainClk,
    input  logic                  io_reset,
    input  logic                  io_a_req,
    input  logic                  io_b_req,
    input  logic                  io_a_we,
    input  logic                  io_b_we,
    input  logic [ADDR_WIDTH-1:0] io_a_addr,
    input  logic [ADDR_WIDTH-1:0] io_b_addr,
    input  logic [DATA_WIDTH-1:0] io_a_wdata,
    input  logic [DATA_WIDTH-1:0] io_b_wdata,
    input  logic [1:0]            io_a_mask,
    input  logic [1:0]            io_b_mask,
    output logic                  io_a_ack,
    output logic                  io_b_ack,
    output logic [DATA_WIDTH-1:0] io_a_rdata,
    output logic [DATA_WIDTH-1:0] io_b_rdata,
    output logic [ADDR_WIDTH-1:0] io_sram_addr,
    input  logic [DATA_WIDTH-1:0] io_sram_dat_read,
    output logic [DATA_WIDTH-1:0] io_sram_dat_write,
    output logic                  io_sram_dat_writeEnable,
    output logic                  io_sram_cs,
    output logic                  io_sram_oe,
    output logic                  io_sram_we,
    output logic                  io_sram_lb,
    output logic                  io_sram_ub
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    sram_state_e           state, state_next;
    logic [3:0]            wait_cnt, wait_cnt_next;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [1:0]            lat_mask;
    grant_id_e             lat_gid;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

    logic      grant_valid;
    grant_id_e grant_id;
    logic      grant_take;
    logic      capture;

    assign grant_take = (state == IDLE) && grant_valid;
    assign capture    = (state == ACCESS) && (wait_cnt == 4'd0) && !lat_we;

    sram_rr_arb u_arb (
        .CLK         (io_mainClk),
        .reset_in    (io_reset),
        .req_a       (io_a_req),
        .req_b       (io_b_req),
        .advance     (grant_take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign io_sram_addr      = lat_addr;
    assign io_sram_dat_write = lat_wdata;
    assign io_a_rdata        = a_rdata;
    assign io_b_rdata        = b_rdata;

    // State, wait counter, request latches and read-data capture.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_mask  <= '0;
            lat_gid   <= PORT_A;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (grant_take) begin
                lat_gid <= grant_id;
                if (grant_id == PORT_A) begin
                    lat_we    <= io_a_we;
                    lat_addr  <= io_a_addr;
                    lat_wdata <= io_a_wdata;
                    lat_mask  <= io_a_mask;
                end else begin
                    lat_we    <= io_b_we;
                    lat_addr  <= io_b_addr;
                    lat_wdata <= io_b_wdata;
                    lat_mask  <= io_b_mask;
                end
            end
            if (capture) begin
                if (lat_gid == PORT_A) begin
                    a_rdata <= io_sram_dat_read;
                end else begin
                    b_rdata <= io_sram_dat_read;
                end
            end
        end
    end

    // Next-state sequencing and active-low strobe decode.
    always_comb begin
        state_next              = state;
        wait_cnt_next           = wait_cnt;
        io_sram_cs              = 1'b1;
        io_sram_oe              = 1'b1;
        io_sram_we              = 1'b1;
        io_sram_lb              = 1'b1;
        io_sram_ub              = 1'b1;
        io_sram_dat_writeEnable = 1'b0;
        io_a_ack                = 1'b0;
        io_b_ack                = 1'b0;

        // Byte lanes stay selected for the whole chip-select window.
        if (state != IDLE) begin
            io_sram_cs = 1'b0;
            if (lat_we) begin
                io_sram_lb = ~lat_mask[0];
                io_sram_ub = ~lat_mask[1];
            end else begin
                io_sram_lb = 1'b0;
                io_sram_ub = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                io_sram_dat_writeEnable = lat_we;
                io_sram_oe              = lat_we;
                wait_cnt_next           = WAIT_LOAD;
                state_next              = ACCESS;
            end
            ACCESS: begin
                io_sram_dat_writeEnable = lat_we;
                io_sram_oe              = lat_we;
                io_sram_we              = ~lat_we;
                if (wait_cnt == 4'd0) begin
                    state_next = HOLD;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            HOLD: begin
                io_sram_dat_writeEnable = lat_we;
                io_a_ack                = (lat_gid == PORT_A);
                io_b_ack                = (lat_gid == PORT_B);
                state_next              = IDLE;
            end
        endcase
    end

endmodule
